// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Package     : stream_pkg
// Description : Shared types for the 3x3 streaming window: default element
//               precision, window type and window-builder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Default signed width of one window element
  localparam int PRECISION_DEF = 16;

  // 3x3 window, [row][col], row 0 = oldest line, col 0 = oldest column
  typedef logic signed [2:0][2:0][PRECISION_DEF-1:0] window_t;

  // Window builder states: idle until a start-of-frame, then streaming
  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_window_3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One line of pixel storage. Asynchronous read of the current
//               address returns the old contents while the synchronous write
//               lands on the same edge (read-before-write). No reset so the
//               array maps onto RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter  int WIDTH     = 640,
  parameter  int PRECISION = 16,
  localparam int AW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [PRECISION-1:0] wdata,
  output logic [PRECISION-1:0] rdata
);

  logic [PRECISION-1:0] r_mem [WIDTH];

  assign rdata = r_mem[addr];

  // Store the new entry; the read above still sees the previous value
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_window_3.sv
`default_nettype none
// ============================================================================
// Module      : stream_window_3
// Description : Builds a sliding 3x3 window over a raster pixel stream using
//               two line buffers. out_valid flags windows lying fully inside
//               the frame (no edge padding).
// Revision    : 1.0 - initial release
// ============================================================================
module stream_window_3
  import stream_pkg::*;
#(
  parameter int PRECISION = PRECISION_DEF,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          in_pixel,
  input  logic                                in_valid,
  input  logic                                in_sof,
  output logic signed [2:0][2:0][PRECISION-1:0] buffer_3,
  output logic                                out_valid
);

  localparam int            CW         = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int            RW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] c_COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] c_COL_ONE  = CW'(1);
  localparam logic [RW-1:0] c_ROW_ONE  = RW'(1);

  state_t                         r_state;
  logic [CW-1:0]                  r_col;
  logic [RW-1:0]                  r_row;
  logic [2:0][2:0][PRECISION-1:0] r_win;
  logic                           r_valid;

  logic                 w_take;
  logic [CW-1:0]        w_col;
  logic [RW-1:0]        w_row;
  logic [CW-1:0]        w_col_nxt;
  logic [RW-1:0]        w_row_nxt;
  logic [PRECISION-1:0] w_pix;
  logic [PRECISION-1:0] w_l1_rd;
  logic [PRECISION-1:0] w_l2_rd;

  // A pixel is consumed when streaming, or when it carries start-of-frame
  assign w_take = in_valid && (in_sof || (r_state == STREAM));
  // Start-of-frame forces the pixel to position (0,0) regardless of counters
  assign w_col  = in_sof ? '0 : r_col;
  assign w_row  = in_sof ? '0 : r_row;
  assign w_pix  = {{(PRECISION-8){1'b0}}, in_pixel};

  // L1 holds the previous line; L2 receives what L1 held (two lines back)
  line_buffer #(.WIDTH(WIDTH), .PRECISION(PRECISION)) u_l1 (
    .clk   (clk),
    .we    (w_take),
    .addr  (w_col),
    .wdata (w_pix),
    .rdata (w_l1_rd)
  );

  line_buffer #(.WIDTH(WIDTH), .PRECISION(PRECISION)) u_l2 (
    .clk   (clk),
    .we    (w_take),
    .addr  (w_col),
    .wdata (w_l1_rd),
    .rdata (w_l2_rd)
  );

  // Raster position following the pixel being accepted
  always_comb begin
    w_col_nxt = w_col + c_COL_ONE;
    w_row_nxt = w_row;
    if (w_col == c_COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == c_ROW_LAST) ? '0 : (w_row + c_ROW_ONE);
    end
  end

  // FSM, raster counters, window shift register and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_SOF;
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_take) begin
        r_state <= STREAM;
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_l2_rd;
        r_win[1][2] <= w_l1_rd;
        r_win[2][2] <= w_pix;
        // Only windows with two full lines and two full columns behind them
        r_valid     <= (w_row > c_ROW_ONE) && (w_col > c_COL_ONE);
      end
    end
  end

  assign buffer_3  = r_win;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_window_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_window_3
// Description : Scoreboard bench for stream_window_3 (4x4 frames). A frame
//               model predicts windows as pixels are issued; a monitor pops
//               and compares each presented window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_window_3;
  import stream_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = PRECISION_DEF;

  typedef logic [2:0][2:0][P-1:0] win_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       in_valid = 1'b0;
  logic       in_sof   = 1'b0;
  window_t    buffer_3;
  logic       out_valid;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_pulses = 0;
  win_t exp_q[$];

  // Reference model: current frame contents by position
  int   frame [H][W];
  bit   m_active = 1'b0;
  int   m_row    = 0;
  int   m_col    = 0;
  win_t m_last   = '0;

  always #5 clk = ~clk;

  stream_window_3 #(.PRECISION(P), .WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .buffer_3  (buffer_3),
    .out_valid (out_valid)
  );

  task automatic check(input string nm, input logic [143:0] act, input logic [143:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic win_t win_of(input int r, input int c);
    win_t w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[rr][cc] = P'(frame[r-2+rr][c-2+cc]);
    return w;
  endfunction

  // Window whose top-left pixel value is tl in a frame of value base+4*row+col
  function automatic win_t lit_win(input int tl);
    win_t w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[rr][cc] = P'(tl + W*rr + cc);
    return w;
  endfunction

  task automatic model_accept(input int pix, input bit sof);
    if (sof) begin
      m_active = 1'b1;
      m_row    = 0;
      m_col    = 0;
    end
    if (!m_active) return;
    frame[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      m_last = win_of(m_row, m_col);
      exp_q.push_back(m_last);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row + 1) % H;
    end
  endtask

  task automatic send(input int pix, input bit sof);
    in_pixel = pix[7:0];
    in_sof   = sof;
    in_valid = 1'b1;
    model_accept(pix, sof);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < W*H; i++) send(base + i, i == 0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
    #1;
    check("reset_out_valid", 144'(out_valid), 144'(0));
    check("reset_window", buffer_3, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every presented window must match the oldest prediction
  always @(negedge clk) begin
    win_t e;
    if (reset && out_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got out_valid=1 window %h expected no window", buffer_3);
      end else begin
        e = exp_q.pop_front();
        check("window", buffer_3, e);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("por_out_valid", 144'(out_valid), 144'(0));
    check("por_window", buffer_3, '0);
    reset = 1'b1;
    idle(1);

    // Continuous frame: four pulses, last window centred on pixel 10
    n_pulses = 0;
    send_frame(0);
    idle(2);
    check("frame_pulses", 144'(n_pulses), 144'(4));
    check("frame_last_window", buffer_3, lit_win(5));

    // Gap between pixels 10 and 11 holds window and keeps out_valid low
    do_reset();
    for (int i = 0; i <= 10; i++) send(i, i == 0);
    for (int g = 0; g < 3; g++) begin
      idle(1);
      check("gap_out_valid", 144'(out_valid), 144'(0));
      check("gap_window", buffer_3, m_last);
    end
    for (int i = 11; i < W*H; i++) send(i, 1'b0);
    idle(1);

    // Pixels before any start-of-frame are ignored
    do_reset();
    n_pulses = 0;
    send(7, 1'b0);
    send(8, 1'b0);
    send(9, 1'b0);
    idle(2);
    check("no_sof_pulses", 144'(n_pulses), 144'(0));
    send_frame(0);
    idle(1);

    // Reset right after pixel 10 clears output immediately
    do_reset();
    for (int i = 0; i <= 10; i++) send(i, i == 0);
    do_reset();
    send_frame(0);
    idle(1);

    // Back-to-back frames
    send_frame(0);
    send_frame(100);
    idle(1);
    check("second_frame_last", buffer_3, lit_win(105));

    // Randomized stream with gaps, mid-frame restarts and resets
    do_reset();
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) do_reset();
      else if (r < 80) send($urandom_range(0, 255), ($urandom_range(0, 39) == 0) || (k == 0));
      else idle(1);
    end

    idle(3);
    check("queue_drained", 144'(exp_q.size()), 144'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
